// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and the registered status-flag layout for the FIFO pointer controller.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned AFULL_LVL_DEF  = 6;
  localparam int unsigned AEMPTY_LVL_DEF = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{full: 1'b0, empty: 1'b1,
                                            almost_full: 1'b0, almost_empty: 1'b1};

endpackage

// File: rtl/fifo_ptr.sv
// Binary FIFO pointer: increments by one when enabled, wrapping naturally at ADDR_W bits.
module fifo_ptr #(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller for the fifo_mem array; optional sticky overflow/underflow
// flags are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AFULL_LVL  = AFULL_LVL_DEF,
  parameter int unsigned AEMPTY_LVL = AEMPTY_LVL_DEF,
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_enable,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_enable,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO_CTRL_ERR_EN
  , input  logic            err_clr
  , output logic            overflow
  , output logic            underflow
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);

  logic [ADDR_W:0] count_q, count_d;
  fifo_status_t    status_q, status_d;
  logic            rd_valid_q;

  // Enables depend only on registered flags, so wr_req never reaches read_enable.
  assign write_enable = wr_req & ~status_q.full;
  assign read_enable  = rd_req & ~status_q.empty;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (write_enable),
    .ptr_o  (write_address)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (read_enable),
    .ptr_o  (read_address)
  );

  always_comb begin
    count_d = count_q;
    case ({write_enable, read_enable})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    status_d.full         = (count_d == DEPTH_C);
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= AFULL_C);
    status_d.almost_empty = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      status_q   <= STATUS_RESET;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      status_q   <= status_d;
      rd_valid_q <= read_enable;
    end
  end

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign rd_valid     = rd_valid_q;

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A set event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_req & status_q.full)  overflow_d  = 1'b1;
    if (rd_req & status_q.empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: directed scenarios plus random traffic against an occupancy model.
module tb_fifo_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AFULL  = 6;
  localparam int unsigned AEMPTY = 2;
  localparam int unsigned AW     = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_req, rd_req;
  logic [AW-1:0] write_address, read_address;
  logic          write_enable, read_enable, rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
`ifdef FIFO_CTRL_ERR_EN
  logic          err_clr, overflow, underflow;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model state: occupancy, totals of accepted operations, last-cycle read acceptance.
  int unsigned n_m, wr_tot_m, rd_tot_m;
  logic        rdv_m, ovf_m, unf_m;
  logic        clr_v;

  fifo_ctrl #(.FIFO_DEPTH(DEPTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .write_address (write_address),
    .write_enable  (write_enable),
    .read_address  (read_address),
    .read_enable   (read_enable),
    .rd_valid      (rd_valid),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count)
`ifdef FIFO_CTRL_ERR_EN
    , .err_clr     (err_clr)
    , .overflow    (overflow)
    , .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_m = 0; wr_tot_m = 0; rd_tot_m = 0;
    rdv_m = 1'b0; ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  task automatic check_all();
    chk("write_enable", 32'(write_enable), 32'(wr_req && n_m < DEPTH));
    chk("read_enable",  32'(read_enable),  32'(rd_req && n_m > 0));
    chk("write_address", 32'(write_address), wr_tot_m % DEPTH);
    chk("read_address",  32'(read_address),  rd_tot_m % DEPTH);
    chk("count",         32'(count),         n_m);
    chk("full",          32'(full),          32'(n_m == DEPTH));
    chk("empty",         32'(empty),         32'(n_m == 0));
    chk("almost_full",   32'(almost_full),   32'(n_m >= AFULL));
    chk("almost_empty",  32'(almost_empty),  32'(n_m <= AEMPTY));
    chk("rd_valid",      32'(rd_valid),      32'(rdv_m));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow",      32'(overflow),      32'(ovf_m));
    chk("underflow",     32'(underflow),     32'(unf_m));
`endif
  endtask

  // Drive one cycle of requests, check before the edge, then advance the model across the edge.
  task automatic step(input logic wr, input logic rd, input logic clr);
    logic we, re;
    wr_req = wr;
    rd_req = rd;
`ifdef FIFO_CTRL_ERR_EN
    err_clr = clr;
`endif
    #1;
    check_all();
    we = wr && (n_m < DEPTH);
    re = rd && (n_m > 0);
    if (wr && n_m == DEPTH) ovf_m = 1'b1;
    else if (clr)           ovf_m = 1'b0;
    if (rd && n_m == 0)     unf_m = 1'b1;
    else if (clr)           unf_m = 1'b0;
    @(posedge clk);
    if (we) begin n_m++; wr_tot_m++; end
    if (re) begin n_m--; rd_tot_m++; end
    rdv_m = re;
    #1;
  endtask

  initial begin
    reset = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    err_clr = 1'b0;
`endif
    model_reset();
    #12;
    check_all();
    reset = 1'b1;

    // Fill to full, then one refused write.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("full_after_8", 32'(full), 32'd1);
    step(1'b1, 1'b0, 1'b0);

    // Drain, then one refused read; final idle cycle shows the last rd_valid.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0);
    chk("empty_after_8", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Empty with both requests: write only.
    step(1'b1, 1'b1, 1'b0);
    chk("count_empty_both", 32'(count), 32'd1);
    step(1'b0, 1'b0, 1'b0);

    // Full with both requests: read only.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("count_full_both", 32'(count), 32'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);

    // Fill 5 / drain 5 three times so both pointers wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(1'b1, 1'b0, 1'b0);
        chk("count_le5_fill", 32'(count <= 4'd5), 32'd1);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    end

    // Random traffic with a mild bias so both full and empty get visited.
    for (int i = 0; i < 400; i++) begin
      logic w, rq;
      if ((i / 50) % 2 == 0) begin
        w  = ($urandom_range(0, 3) != 0);
        rq = ($urandom_range(0, 3) == 0);
      end else begin
        w  = ($urandom_range(0, 3) == 0);
        rq = ($urandom_range(0, 3) != 0);
      end
      clr_v = ($urandom_range(0, 7) == 0);
      step(w, rq, clr_v);
    end

    // Asynchronous reset between edges with four entries held.
    while (n_m > 0) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk("count_before_reset", 32'(count), 32'd4);
    wr_req = 1'b0; rd_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #3;
    reset = 1'b1;
    #1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
